// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Arbitrates the single register-file write port between load returns and
// execute-stage results. Loads cannot be stalled, so they always take the
// port; execute results are parked in a small FIFO and drain whenever the
// port is free. A registered output stage drives the register file.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ex_valid/ex_ready           execute result handshake
//   ex_rd, ex_wd_sel            destination and source select (10 = PC+4)
//   ex_alu_result, ex_pc4       candidate write data
//   ld_valid, ld_rd, ld_data    load return, consumed the cycle it is valid
//   rf_we/rf_waddr/rf_wdata     register-file write port
//   wd_sel                      source of current write: 00 ALU, 01 DRAM, 10 PC+4
//   chk_rs/chk_hit              pending-destination lookup for hazard logic
//   stall_cnt                   saturating count of refused execute offers
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [1:0]        ex_wd_sel,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_pc4,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        wd_sel,
  input  logic [ADDR_W-1:0] chk_rs,
  output logic              chk_hit,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_DRAM = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
  logic [1:0]        fifo_sel_q  [DEPTH];
  logic [1:0]        fifo_sel_d  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              init_q;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]        wd_sel_q, wd_sel_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              push, pop;
  logic [PTR_W-1:0]  scan_idx;
  logic              hit;

  // init_q keeps ex_ready low during reset and for the release cycle,
  // since an empty FIFO would otherwise report ready while held in reset.
  assign ex_ready = init_q && (count_q < LVL_W'(DEPTH));
  assign push     = ex_valid && ex_ready;
  assign pop      = !ld_valid && (count_q != '0);

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_sel_d  = fifo_sel_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // Data is resolved here so the queue only carries the final write value.
    if (push) begin
      fifo_rd_d[wr_ptr_q] = ex_rd;
      if (ex_wd_sel == SEL_PC4) begin
        fifo_sel_d[wr_ptr_q]  = SEL_PC4;
        fifo_data_d[wr_ptr_q] = ex_pc4;
      end else begin
        fifo_sel_d[wr_ptr_q]  = SEL_ALU;
        fifo_data_d[wr_ptr_q] = ex_alu_result;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output stage: a consumed slot always updates address/data/select, but
  // writes to x0 are suppressed through the enable only.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wd_sel_d   = wd_sel_q;
    if (ld_valid) begin
      rf_we_d    = (ld_rd != '0);
      rf_waddr_d = ld_rd;
      rf_wdata_d = ld_data;
      wd_sel_d   = SEL_DRAM;
    end else if (pop) begin
      rf_we_d    = (fifo_rd_q[rd_ptr_q] != '0);
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
      wd_sel_d   = fifo_sel_q[rd_ptr_q];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ex_valid && !ex_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Only occupied slots (counted from the head) take part in the lookup.
  always_comb begin
    hit      = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if ((LVL_W'(i) < count_q) && (fifo_rd_q[scan_idx] == chk_rs)) begin
        hit = 1'b1;
      end
    end
    if (rf_we_q && (rf_waddr_q == chk_rs)) begin
      hit = 1'b1;
    end
    chk_hit = hit && (chk_rs != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_sel_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      wd_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_sel_q  <= fifo_sel_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      init_q      <= 1'b1;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      wd_sel_q    <= wd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign wd_sel    = wd_sel_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_rd = '0;
  logic [1:0]        ex_wd_sel = '0;
  logic [DATA_W-1:0] ex_alu_result = '0;
  logic [DATA_W-1:0] ex_pc4 = '0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [1:0]        wd_sel;
  logic [ADDR_W-1:0] chk_rs = '0;
  logic              chk_hit;
  logic [CNT_W-1:0]  stall_cnt;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wd_sel(ex_wd_sel),
    .ex_alu_result(ex_alu_result), .ex_pc4(ex_pc4),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wd_sel(wd_sel),
    .chk_rs(chk_rs), .chk_hit(chk_hit), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending writes plus the last port write.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic [1:0]        m_sel;
  logic [CNT_W-1:0]  m_stall;
  bit                m_init;

  int errors = 0;
  int checks = 0;

  function automatic bit m_ready();
    return m_init && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_hit(input logic [ADDR_W-1:0] rs);
    if (rs == 0) return 1'b0;
    if (m_we && m_waddr == rs) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = 0; ex_wd_sel = 0; ex_alu_result = 0; ex_pc4 = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  // Advance the model by the rules, then clock the DUT; returns at negedge.
  task automatic step();
    bit   rdy;
    ent_t e;
    ent_t h;
    rdy = m_ready();
    if (ex_valid && !rdy && m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
    e.rd   = ex_rd;
    e.sel  = (ex_wd_sel == 2'b10) ? 2'b10 : 2'b00;
    e.data = (ex_wd_sel == 2'b10) ? ex_pc4 : ex_alu_result;
    if (ld_valid) begin
      m_we = (ld_rd != 0); m_waddr = ld_rd; m_wdata = ld_data; m_sel = 2'b01;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_we = (h.rd != 0); m_waddr = h.rd; m_wdata = h.data; m_sel = h.sel;
    end else begin
      m_we = 0;
    end
    if (ex_valid && rdy) mq.push_back(e);
    m_init = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    chk_rs = 0;
    mq.delete();
    m_we = 0; m_waddr = 0; m_wdata = 0; m_sel = 0; m_stall = 0; m_init = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_init_ready: got %0b want 1", ex_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_init_we: got %0b want 0", rf_we); end
    // build up two queued entries behind a load stream, plus one stall
    ld_valid = 1; ld_rd = 2; ld_data = 32'h1111_0000;
    ex_valid = 1; ex_rd = 4; ex_alu_result = 32'h44;
    repeat (3) step();
    chk_rs = 4;
    #1;
    checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL rst_pre_hit: got %0b want 1", chk_hit); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL rst_pre_stall: got %0d want 1", stall_cnt); end
    #1 rst_n = 0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %0h want 0", rf_waddr); end
    checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", rf_wdata); end
    checks++; if (wd_sel !== 2'b00) begin errors++; $display("FAIL rst_sel: got %0b want 0", wd_sel); end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", ex_ready); end
    checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %0b want 0", chk_hit); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    apply_reset();
    step();
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %0b want 1", ex_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rel_we[%0d]: got %0b want 0", i, rf_we); end
      step();
    end
  endtask

  task automatic test_single_alu();
    ex_valid = 1; ex_rd = 5; ex_wd_sel = 2'b00; ex_alu_result = 32'h1234; ex_pc4 = 32'h8888;
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_early_we: got %0b want 0", rf_we); end
    step();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata: got %0h want 1234", rf_wdata); end
    checks++; if (wd_sel !== 2'b00) begin errors++; $display("FAIL alu_sel: got %0b want 00", wd_sel); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_after_we: got %0b want 0", rf_we); end
  endtask

  task automatic test_collision();
    ex_valid = 1; ex_rd = 1; ex_wd_sel = 2'b10; ex_pc4 = 32'h104; ex_alu_result = 32'hBAD;
    ld_valid = 1; ld_rd = 7; ld_data = 32'hDEAD;
    step();
    idle_inputs();
    checks++; if ({rf_we, rf_waddr, wd_sel} !== {1'b1, 5'd7, 2'b01}) begin errors++; $display("FAIL coll_ld: got we=%0b a=%0d s=%0b want 1/7/01", rf_we, rf_waddr, wd_sel); end
    checks++; if (rf_wdata !== 32'hDEAD) begin errors++; $display("FAIL coll_ld_data: got %0h want dead", rf_wdata); end
    step();
    checks++; if ({rf_we, rf_waddr, wd_sel} !== {1'b1, 5'd1, 2'b10}) begin errors++; $display("FAIL coll_jal: got we=%0b a=%0d s=%0b want 1/1/10", rf_we, rf_waddr, wd_sel); end
    checks++; if (rf_wdata !== 32'h104) begin errors++; $display("FAIL coll_jal_data: got %0h want 104", rf_wdata); end
  endtask

  task automatic test_backpressure();
    logic       exp_rdy [5];
    logic [4:0] ex_rds  [5];
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex_rds  = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd12};
    apply_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1; ld_rd = 5'd20 + 5'(i); ld_data = 32'hD000 + i;
      ex_valid = 1; ex_rd = ex_rds[i]; ex_wd_sel = 2'b00; ex_alu_result = 32'h0 + {ex_rds[i], 4'h0};
      #1;
      checks++; if (ex_ready !== exp_rdy[i]) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want %0b", i, ex_ready, exp_rdy[i]); end
      step();
      checks++; if (rf_waddr !== 5'd20 + 5'(i) || rf_wdata !== 32'hD000 + i) begin errors++; $display("FAIL bp_load[%0d]: got %0d/%0h", i, rf_waddr, rf_wdata); end
    end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL bp_stall: got %0d want 3", stall_cnt); end
    idle_inputs();
    step();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA0}) begin errors++; $display("FAIL bp_drain0: got we=%0b a=%0d d=%0h want 1/10/a0", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'hB0}) begin errors++; $display("FAIL bp_drain1: got we=%0b a=%0d d=%0h want 1/11/b0", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL bp_empty: got we=%0b rdy=%0b want 0/1", rf_we, ex_ready); end
  endtask

  task automatic test_x0();
    ex_valid = 1; ex_rd = 0; ex_wd_sel = 2'b00; ex_alu_result = 32'h55;
    step();
    idle_inputs();
    chk_rs = 0;
    #1;
    checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL x0_hit: got %0b want 0", chk_hit); end
    step();
    checks++; if ({rf_we, rf_waddr, wd_sel} !== {1'b0, 5'd0, 2'b00} || rf_wdata !== 32'h55) begin errors++; $display("FAIL x0_ex: got we=%0b a=%0d s=%0b d=%0h", rf_we, rf_waddr, wd_sel, rf_wdata); end
    ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
    step();
    idle_inputs();
    checks++; if ({rf_we, wd_sel} !== {1'b0, 2'b01} || rf_wdata !== 32'h77) begin errors++; $display("FAIL x0_ld: got we=%0b s=%0b d=%0h", rf_we, wd_sel, rf_wdata); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL x0_slot_freed: got %0b want 1", ex_ready); end
  endtask

  task automatic test_hazard();
    chk_rs = 9;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h3333;
    ex_valid = 1; ex_rd = 9; ex_wd_sel = 2'b00; ex_alu_result = 32'h99;
    step();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL hz_queued[%0d]: got %0b want 1", i, chk_hit); end
      if (i == 2) ld_valid = 0;
      step();
    end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || chk_hit !== 1'b1) begin errors++; $display("FAIL hz_write: got we=%0b a=%0d hit=%0b", rf_we, rf_waddr, chk_hit); end
    step();
    checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL hz_clear: got %0b want 0", chk_hit); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    step();
    ld_valid = 1; ld_rd = 6; ld_data = 32'h6;
    ex_valid = 1; ex_rd = 8; ex_alu_result = 32'h8;
    repeat (20) step();
    checks++; if (stall_cnt !== CNT_MAX) begin errors++; $display("FAIL sat_stall: got %0d want %0d", stall_cnt, CNT_MAX); end
    checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL sat_model: got %0d want %0d", stall_cnt, m_stall); end
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    step();
    for (int n = 0; n < 400; n++) begin
      ld_valid      = ($urandom_range(0, 99) < 45);
      ld_rd         = 5'($urandom_range(0, 7));
      ld_data       = $urandom;
      ex_valid      = ($urandom_range(0, 99) < 60);
      ex_rd         = 5'($urandom_range(0, 7));
      ex_wd_sel     = 2'($urandom_range(0, 3));
      ex_alu_result = $urandom;
      ex_pc4        = $urandom;
      chk_rs        = 5'($urandom_range(0, 7));
      #1;
      checks++; if (ex_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, ex_ready, m_ready()); end
      checks++; if (chk_hit !== m_hit(chk_rs)) begin errors++; $display("FAIL rnd_hit[%0d]: got %0b want %0b rs=%0d", n, chk_hit, m_hit(chk_rs), chk_rs); end
      step();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || wd_sel !== m_sel || stall_cnt !== m_stall) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got we=%0b a=%0d d=%0h s=%0b st=%0d want we=%0b a=%0d d=%0h s=%0b st=%0d",
                 n, rf_we, rf_waddr, rf_wdata, wd_sel, stall_cnt, m_we, m_waddr, m_wdata, m_sel, m_stall);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_backpressure();
    test_x0();
    test_hazard();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and sequencer for the single register-file write port of the RV32I core. It accepts execute-stage results (ALU or PC+4) through a valid/ready handshake and load returns from data memory (no backpressure). Load returns always win the port; execute results wait in a small FIFO. It drives the write-back select code, data, address and write enable toward the register file, and exposes a pending-destination lookup for hazard detection.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- DEPTH, 2, execute-result FIFO entries (power of two, ≥2)
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute result offered
- ex_ready  out  1  FIFO can accept
- ex_rd  in  ADDR_W  destination register
- ex_wd_sel  in  2  00 = ALU result, 10 = PC+4 (01/11 illegal, treated as 00)
- ex_alu_result  in  DATA_W  ALU result
- ex_pc4  in  DATA_W  PC+4 of the instruction
- ld_valid  in  1  load data return, must be consumed this cycle
- ld_rd  in  ADDR_W  load destination
- ld_data  in  DATA_W  loaded word
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- wd_sel  out  2  source code of current write: 00 ALU, 01 DRAM, 10 PC+4
- chk_rs  in  ADDR_W  register to check
- chk_hit  out  1  chk_rs ≠ 0 and matches rd of a FIFO entry or of a valid output stage
- stall_cnt  out  CNT_W  saturating count of cycles with ex_valid=1 and ex_ready=0

## Operation
- FIFO stores {rd, sel, data}. Data is resolved on enqueue: ex_pc4 if ex_wd_sel=10, else ex_alu_result.
- Enqueue on rising edge when ex_valid && ex_ready. ex_ready = (count < DEPTH), from registered count only; no same-cycle enqueue on a full FIFO even if a dequeue occurs.
- Port selection, every cycle: ld_valid=1 → load wins, output stage loads {ld_rd, 01, ld_data}. Otherwise, if FIFO is non-empty, the head pops and loads the output stage. Otherwise the output stage loads rf_we=0.
- x0 writes: an entry or load with rd=0 still consumes the port slot, but the output stage loads rf_we=0. wd_sel/rf_waddr/rf_wdata then hold the consumed values.
- Enqueue and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- chk_hit is combinational over the valid FIFO entries and the output stage (rf_we=1). It does not include ld_rd in flight.
- Ordering: load return and a queued entry to the same rd are write-after-write. The issue logic prevents this using chk_hit. The block does not reorder or merge.
- stall_cnt increments on each stall cycle and saturates at all-ones. It never wraps.

## Timing
- Reset (asserted asynchronously, released synchronously by design): rf_we=0, rf_waddr=0, rf_wdata=0, wd_sel=00, ex_ready=0 while rst_n=0 then 1 from the first cycle after release, chk_hit=0 (FIFO empty), stall_cnt=0.
- Reset mid-operation discards all queued entries and the output stage. No write occurs.
- Load latency: ld_valid sampled at edge N → rf_we=1 during cycle N..N+1.
- Execute latency (FIFO empty, no load): accepted at edge N → popped at edge N+1 → rf_we=1 during cycle N+1..N+2. Back-to-back accepted results write on consecutive cycles.
- Each cycle of continuous ld_valid delays the FIFO head by one cycle. ex_ready drops after DEPTH accepts.
- Output registers change only on rising clk or reset.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 queued entries → all outputs 0 and chk_hit=0 immediately; after release ex_ready=1 and no rf_we pulse.
- Single ALU op: ex_rd=5, sel=00, alu=0x1234 accepted at edge 1 → rf_we=1, rf_waddr=5, rf_wdata=0x1234, wd_sel=00 after edge 2.
- Collision: JAL ex_rd=1, pc4=0x104 accepted the same cycle as ld_valid (rd=7, 0xDEAD) → load written first (wd_sel=01), then x1=0x104 with wd_sel=10 on the next cycle.
- Backpressure: ld_valid held high for 5 cycles with ex_valid constant → ex_ready=0 after 2 accepts, stall_cnt=3, and entries drain in order once ld_valid drops.
- x0: ex_rd=0 and ld_rd=0 → slot consumed, rf_we stays 0; chk_rs=0 → chk_hit=0.
- Hazard lookup: queue ex_rd=9 behind a load stream → chk_rs=9 gives chk_hit=1 until the cycle after its rf_we pulse, then 0.
